// File: rtl/inv_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// inv_sqrt_arbiter
//
// Lets NUM_REQ requesters in the normalization datapath share one external,
// purely combinational inverse-square-root lookup table (3.8 unsigned operand,
// 2.5 unsigned result).
//
// Datapath:
//   requesters --(round-robin grant)--> stage A --lut_in/lut_out--> stage B
//   stage B --> response port (one-hot rsp_valid addressed to the requester)
//
// Stage A holds the granted operand and its requester index; its data
// register drives lut_in directly, so the LUT settles within that cycle and
// its result is captured into stage B on the A->B transfer. Both stages
// advance together, so one result per cycle is sustained while the
// addressed requester keeps rsp_ready high.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset, flushes both stages
//   req_valid  per-requester request valid
//   req_data   packed operands, requester i at [i*IN_W +: IN_W]
//   req_ready  one-hot grant (at most one bit high)
//   lut_in     operand to the external LUT (stage-A data)
//   lut_out    combinational LUT result for lut_in
//   rsp_valid  one-hot response valid, bit k addresses requester k
//   rsp_data   LUT result for the presented response
//   rsp_sat    operand was below 16 (result saturated by the LUT)
//   rsp_ready  per-requester response accept
//   idle       both pipeline stages empty
// -----------------------------------------------------------------------------
module inv_sqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 11,
    parameter int OUT_W   = 7,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         lut_in,
    input  logic [OUT_W-1:0]        lut_out,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [OUT_W-1:0]        rsp_data,
    output logic                    rsp_sat,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    idle
);

    // Operands below this value (1/16 in 3.8) have an inverse square root
    // that does not fit the 2.5 output; the LUT saturates them.
    localparam logic [IN_W-1:0] SAT_LIMIT = IN_W'(16);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             a_vld_reg,  a_vld_next;
    logic [ID_W-1:0]  a_id_reg,   a_id_next;
    logic [IN_W-1:0]  a_data_reg, a_data_next;

    logic             b_vld_reg,  b_vld_next;
    logic [ID_W-1:0]  b_id_reg,   b_id_next;
    logic [OUT_W-1:0] b_data_reg, b_data_next;
    logic             b_sat_reg,  b_sat_next;

    logic [ID_W-1:0]  ptr_reg,    ptr_next;

    // -------------------------------------------------------------------------
    // Per-requester operand unpacking and response addressing
    // -------------------------------------------------------------------------
    logic [IN_W-1:0]    req_data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] b_onehot;
    logic [NUM_REQ-1:0] win_onehot;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data[gi*IN_W +: IN_W];
            assign b_onehot[gi]     = (b_id_reg == ID_W'(gi));
            assign win_onehot[gi]   = win_found && (win_idx == ID_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pipeline flow control
    // -------------------------------------------------------------------------
    logic b_fire;
    logic b_free;
    logic a_free;
    logic a_to_b;
    logic grant_fire;

    // Selecting rsp_ready through the one-hot id avoids indexing a NUM_REQ-wide
    // vector with an index that may span more values than NUM_REQ.
    assign b_fire = b_vld_reg && ((rsp_ready & b_onehot) != '0);
    assign b_free = !b_vld_reg || b_fire;
    assign a_free = !a_vld_reg || b_free;
    assign a_to_b = a_vld_reg && b_free;

    // -------------------------------------------------------------------------
    // Round-robin arbitration: scan ptr, ptr+1, ... wrapping at NUM_REQ.
    // The wrap is done by a conditional subtract so that non-power-of-2
    // requester counts never reach an unused index.
    // -------------------------------------------------------------------------
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Grants are suppressed while reset is asserted so no requester sees a
    // handshake that the flushed pipeline would not honour.
    assign req_ready  = win_onehot & {NUM_REQ{a_free && !rst}};
    assign grant_fire = win_found && a_free;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        a_vld_next  = a_vld_reg;
        a_id_next   = a_id_reg;
        a_data_next = a_data_reg;
        b_vld_next  = b_vld_reg;
        b_id_next   = b_id_reg;
        b_data_next = b_data_reg;
        b_sat_next  = b_sat_reg;
        ptr_next    = ptr_reg;

        // Stage A: a new grant may load A in the same cycle A hands its
        // operand to B, which is what keeps the pipeline at full rate.
        if (grant_fire) begin
            a_vld_next  = 1'b1;
            a_id_next   = win_idx;
            a_data_next = req_data_arr[win_idx];
            ptr_next    = (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);
        end else if (a_to_b) begin
            a_vld_next = 1'b0;
        end

        // Stage B: capture the LUT result for the operand currently in A.
        if (a_to_b) begin
            b_vld_next  = 1'b1;
            b_id_next   = a_id_reg;
            b_data_next = lut_out;
            b_sat_next  = (a_data_reg < SAT_LIMIT);
        end else if (b_fire) begin
            b_vld_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld_reg  <= 1'b0;
            a_id_reg   <= '0;
            a_data_reg <= '0;
            b_vld_reg  <= 1'b0;
            b_id_reg   <= '0;
            b_data_reg <= '0;
            b_sat_reg  <= 1'b0;
            ptr_reg    <= '0;
        end else begin
            a_vld_reg  <= a_vld_next;
            a_id_reg   <= a_id_next;
            a_data_reg <= a_data_next;
            b_vld_reg  <= b_vld_next;
            b_id_reg   <= b_id_next;
            b_data_reg <= b_data_next;
            b_sat_reg  <= b_sat_next;
            ptr_reg    <= ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign lut_in    = a_data_reg;
    assign rsp_valid = b_vld_reg ? b_onehot : '0;
    assign rsp_data  = b_data_reg;
    assign rsp_sat   = b_sat_reg && b_vld_reg;
    assign idle      = !a_vld_reg && !b_vld_reg;

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inv_sqrt_arbiter
//
// Drives inv_sqrt_arbiter with directed and randomized traffic and compares
// every cycle against a transaction-level model: a queue of granted requests,
// each of which becomes presentable two cycles after its grant and no earlier
// than one cycle after its predecessor was accepted; at most two requests are
// in flight. The external LUT is modelled as 512/sqrt(x), clamped to 7 bits.
// -----------------------------------------------------------------------------
module tb_inv_sqrt_arbiter;

    localparam int N   = 4;
    localparam int IW  = 11;
    localparam int OW  = 7;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*IW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [IW-1:0]   lut_in;
    logic [OW-1:0]   lut_out;
    logic [N-1:0]    rsp_valid;
    logic [OW-1:0]   rsp_data;
    logic            rsp_sat;
    logic [N-1:0]    rsp_ready = '0;
    logic            idle;

    logic [IW-1:0]   rd [N];

    always #5 clk = ~clk;

    inv_sqrt_arbiter #(
        .NUM_REQ (N),
        .IN_W    (IW),
        .OUT_W   (OW),
        .ID_W    (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .lut_in    (lut_in),
        .lut_out   (lut_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_sat   (rsp_sat),
        .rsp_ready (rsp_ready),
        .idle      (idle)
    );

    // Behavioural inverse square root: x is 3.8, result is 2.5, so the
    // result code is 32 / sqrt(x/256) = 512 / sqrt(x).
    function automatic logic [OW-1:0] lut_fn(input logic [IW-1:0] x);
        real r;
        int  v;
        if (x < 16) return 7'h7F;
        r = 512.0 / $sqrt(real'(x));
        v = int'($floor(r));
        if (v > 127) v = 127;
        return 7'(v);
    endfunction

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*IW +: IW] = rd[i];
    end

    always_comb lut_out = lut_fn(lut_in);

    // -------------------------------------------------------------------------
    // Scoreboard / model state
    // -------------------------------------------------------------------------
    typedef struct {
        int            id;
        logic [IW-1:0] data;
        int            gcyc;
    } item_t;

    item_t q[$];
    int    m_ptr    = 0;
    int    cyc      = 0;
    int    last_pop = -100;

    int n_checks = 0;
    int n_pass   = 0;

    logic [N-1:0]  obs_req_ready;
    logic [N-1:0]  obs_rsp_valid;
    logic [OW-1:0] obs_rsp_data;
    logic          obs_rsp_sat;
    logic          obs_idle;
    logic [N-1:0]  last_grant = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)",
                     tag, obs, exp_v, cyc, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr    = 0;
        last_pop = -100;
    endtask

    // One clock cycle: inputs are already driven; check outputs on the falling
    // edge against the model, then advance the model at the rising edge.
    task automatic step();
        int           win;
        bit           found;
        bit           head_vis;
        bit           pop;
        bit           afree;
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_rv;
        item_t        it;

        @(negedge clk);
        obs_req_ready = req_ready;
        obs_rsp_valid = rsp_valid;
        obs_rsp_data  = rsp_data;
        obs_rsp_sat   = rsp_sat;
        obs_idle      = idle;

        found = 1'b0;
        win   = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win   = i;
            end
        end

        head_vis = (q.size() > 0) && (cyc >= q[0].gcyc + 2) && (cyc >= last_pop + 1);
        pop      = head_vis && rsp_ready[q[0].id];
        afree    = (q.size() < 2) || pop;
        exp_rr   = (found && afree) ? (N'(1) << win) : '0;
        exp_rv   = head_vis ? (N'(1) << q[0].id) : '0;

        check("req_ready", 32'(obs_req_ready), 32'(exp_rr));
        check("rsp_valid", 32'(obs_rsp_valid), 32'(exp_rv));
        if (head_vis) begin
            check("rsp_data", 32'(obs_rsp_data), 32'(lut_fn(q[0].data)));
            check("rsp_sat", 32'(obs_rsp_sat), 32'(q[0].data < 16));
        end else begin
            check("rsp_sat_idle", 32'(obs_rsp_sat), 32'(0));
        end
        check("idle", 32'(obs_idle), 32'(q.size() == 0));
        if (q.size() > 0 && !(head_vis && q.size() == 1)) begin
            check("lut_in", 32'(lut_in), 32'(q[q.size()-1].data));
        end

        @(posedge clk);
        if (pop) begin
            $display("rsp  cycle %0d id=%0d op=0x%03h data=0x%02h sat=%0d",
                     cyc, q[0].id, q[0].data, obs_rsp_data, obs_rsp_sat);
            void'(q.pop_front());
            last_pop = cyc;
        end
        if (found && afree) begin
            it.id   = win;
            it.data = rd[win];
            it.gcyc = cyc;
            q.push_back(it);
            m_ptr = (win + 1) % N;
        end
        last_grant = obs_req_ready & req_valid;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) rd[i] = IW'($urandom);
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'(0));
            check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            check("rst_rsp_data", 32'(rsp_data), 32'(0));
            check("rst_idle", 32'(idle), 32'(1));
            check("rst_lut_in", 32'(lut_in), 32'(0));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = '0;
        rst = 1'b0;
        model_reset();
        last_grant = '0;
    endtask

    task automatic single_req(input int id, input logic [IW-1:0] d,
                              input logic [OW-1:0] exp_d, input bit exp_s);
        rsp_ready     = '1;
        req_valid     = '0;
        req_valid[id] = 1'b1;
        rd[id]        = d;
        step();
        check("single_grant", 32'(obs_req_ready), 32'(N'(1) << id));
        req_valid = '0;
        step();
        check("single_no_rsp_t1", 32'(obs_rsp_valid), 32'(0));
        step();
        check("single_rsp_valid", 32'(obs_rsp_valid), 32'(N'(1) << id));
        check("single_rsp_data", 32'(obs_rsp_data), 32'(exp_d));
        check("single_rsp_sat", 32'(obs_rsp_sat), 32'(exp_s));
    endtask

    task automatic random_inputs();
        for (int i = 0; i < N; i++) begin
            // A pending, ungranted request must keep its operand.
            if (!(req_valid[i] && !last_grant[i])) begin
                req_valid[i] = ($urandom_range(99) < 60);
                if ($urandom_range(3) == 0) rd[i] = IW'($urandom_range(31));
                else                        rd[i] = IW'($urandom);
            end
            rsp_ready[i] = ($urandom_range(99) < 70);
        end
    endtask

    initial begin
        logic [OW-1:0] held_data;
        logic [N-1:0]  held_valid;

        for (int i = 0; i < N; i++) rd[i] = '0;

        // Reset with random inputs
        do_reset();

        // Single requests, including the saturation boundary
        single_req(2, 11'h400, 7'b0010000, 1'b0);
        single_req(1, 11'h100, 7'b0100000, 1'b0);
        single_req(3, 11'd8,   7'h7F,      1'b1);
        single_req(0, 11'd16,  7'h7F,      1'b0);

        // Round-robin with all requesters active
        do_reset();
        rsp_ready = '1;
        req_valid = '1;
        for (int i = 0; i < N; i++) rd[i] = IW'(11'h200 + i * 100);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_grant", 32'(obs_req_ready), 32'(N'(1) << (k % N)));
        end

        // Backpressure while streaming
        rsp_ready = '0;
        step();
        held_data  = obs_rsp_data;
        held_valid = obs_rsp_valid;
        check("bp_req_ready", 32'(obs_req_ready), 32'(0));
        for (int k = 0; k < 2; k++) begin
            step();
            check("bp_rsp_data_stable", 32'(obs_rsp_data), 32'(held_data));
            check("bp_rsp_valid_stable", 32'(obs_rsp_valid), 32'(held_valid));
            check("bp_req_ready", 32'(obs_req_ready), 32'(0));
        end
        rsp_ready = '1;
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();
        check("bp_drained_idle", 32'(obs_idle), 32'(1));

        // Mid-operation reset with both stages full
        rsp_ready = '0;
        req_valid = '1;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("midrst_idle", 32'(idle), 32'(1));
        check("midrst_req_ready", 32'(req_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        last_grant = '0;
        rsp_ready  = '1;
        req_valid  = '1;
        step();
        check("post_rst_grant", 32'(obs_req_ready), 32'(1));

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            random_inputs();
            step();
        end

        // Drain, bounded
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 10; k++) step();
        check("final_idle", 32'(obs_idle), 32'(1));
        check("final_queue_empty", 32'(q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
